// File: rtl/srf_read_arbiter.sv
// srf_read_arbiter: shares the SRF dual-stream read port between NUM_REQ dispatchers (round-robin,
// locked bursts, tagged response pipe). Define SRF_ARB_PRIO_EN to give requester 0 priority in ARB.
module srf_read_arbiter #(
    parameter int unsigned NUM_REQ             = 4,
    parameter int unsigned NUM_STREAM_ID       = 5,
    parameter int unsigned MIN_VEC_LENGTH      = 16,
    parameter int unsigned NUM_TILES_PER_SLICE = 20,
    parameter int unsigned SRF_LATENCY         = 1,
    parameter int unsigned MAX_BURST           = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [NUM_REQ-1:0]                                     req,
    input  logic [NUM_REQ-1:0]                                     req_lock,
    input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]                  req_src1,
    input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]                  req_src2,
    output logic [NUM_REQ-1:0]                                     gnt,
    output logic                                                   srf_read_enable,
    output logic [NUM_STREAM_ID-1:0]                               stream_src1,
    output logic [NUM_STREAM_ID-1:0]                               stream_src2,
    input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]     srf_data1,
    input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]     srf_data2,
    output logic                                                   rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]                             rsp_id,
    output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]     rsp_data1,
    output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]     rsp_data2
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, LOCKED} state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] owner;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0] iss_id;
    tag_t            tag_q [SRF_LATENCY];

    logic [ID_W-1:0] win;
    logic            found;
    logic [ID_W:0]   scan;
    logic            accept;

    // Winner selection: owner only while locked, else first requester at or after ptr
    always_comb begin
        win   = '0;
        found = 1'b0;
        scan  = '0;
        gnt   = '0;
        if (state == LOCKED) begin
            win   = owner;
            found = req[owner];
        end else begin
`ifdef SRF_ARB_PRIO_EN
            if (req[0]) begin
                win   = '0;
                found = 1'b1;
            end
`endif
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, ptr} + (ID_W+1)'(k);
                if (scan >= (ID_W+1)'(NUM_REQ)) begin
                    scan = scan - (ID_W+1)'(NUM_REQ);
                end
                if (!found && req[scan[ID_W-1:0]]) begin
                    win   = scan[ID_W-1:0];
                    found = 1'b1;
                end
            end
        end
        if (found && rst) begin
            gnt[win] = 1'b1;
        end
    end

    assign accept = |(req & gnt);

    // Issue register, tag pipe, response capture and arbitration state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ARB;
            ptr             <= '0;
            owner           <= '0;
            cnt             <= '0;
            iss_id          <= '0;
            srf_read_enable <= 1'b0;
            stream_src1     <= '0;
            stream_src2     <= '0;
            for (int unsigned i = 0; i < SRF_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_data1       <= '0;
            rsp_data2       <= '0;
        end else begin
            srf_read_enable <= accept;
            if (accept) begin
                stream_src1 <= req_src1[win];
                stream_src2 <= req_src2[win];
                iss_id      <= win;
            end

            // Tag enters the pipe alongside the read strobe so it meets the data SRF_LATENCY later
            tag_q[0] <= {srf_read_enable, iss_id};
            for (int unsigned i = 1; i < SRF_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end

            rsp_valid <= tag_q[SRF_LATENCY-1].valid;
            if (tag_q[SRF_LATENCY-1].valid) begin
                rsp_id    <= tag_q[SRF_LATENCY-1].id;
                rsp_data1 <= srf_data1;
                rsp_data2 <= srf_data2;
            end

            unique case (state)
                ARB: begin
                    if (accept) begin
                        ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        if (req_lock[win] && (MAX_BURST > 1)) begin
                            owner <= win;
                            cnt   <= CNT_W'(1);
                            state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        if (req_lock[owner] && (cnt != CNT_W'(MAX_BURST - 1))) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            cnt   <= '0;
                            state <= ARB;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_srf_read_arbiter.sv
// Directed bench for srf_read_arbiter: hand-written grant sequences, SRF memory model and
// response scoreboard checked with immediate assertions.
module tb_srf_read_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned SID = 5;
    localparam int unsigned VL  = 16;
    localparam int unsigned NT  = 20;
    localparam int unsigned DW  = VL * NT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]          req      = '0;
    logic [NR-1:0]          req_lock = '0;
    logic [NR-1:0][SID-1:0] req_src1;
    logic [NR-1:0][SID-1:0] req_src2;
    logic [NR-1:0]          gnt;
    logic                   srf_read_enable;
    logic [SID-1:0]         stream_src1;
    logic [SID-1:0]         stream_src2;
    logic [NT-1:0][VL-1:0]  srf_data1 = '0;
    logic [NT-1:0][VL-1:0]  srf_data2 = '0;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [NT-1:0][VL-1:0]  rsp_data1;
    logic [NT-1:0][VL-1:0]  rsp_data2;

    assign req_src1 = {5'd17, 5'd3, 5'd9, 5'd5};
    assign req_src2 = {5'd30, 5'd7, 5'd21, 5'd12};

    srf_read_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_lock(req_lock),
        .req_src1(req_src1), .req_src2(req_src2), .gnt(gnt),
        .srf_read_enable(srf_read_enable), .stream_src1(stream_src1), .stream_src2(stream_src2),
        .srf_data1(srf_data1), .srf_data2(srf_data2), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2)
    );

    function automatic logic [DW-1:0] pat(input logic [SID-1:0] s, input logic [4:0] salt);
        logic [NT-1:0][VL-1:0] d;
        for (int t = 0; t < NT; t++) d[t] = {s, 6'(t), salt};
        return d;
    endfunction

    // SRF with one cycle read latency
    always @(posedge clk) begin
        if (srf_read_enable) begin
            srf_data1 <= pat(stream_src1, 5'h0A);
            srf_data2 <= pat(stream_src2, 5'h15);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { int due; logic [1:0] id; } exp_t;
    exp_t q[$];
    int   iss_cyc = -1;
    logic [SID-1:0] nxt_s1 = '0, nxt_s2 = '0;

    // Per-cycle checker of issue strobe/streams and response stream
    int             rd = 0;
    logic           exp_en, exp_v;
    logic [SID-1:0] hold_s1 = '0, hold_s2 = '0;
    logic [DW-1:0]  last_d1 = '0, last_d2 = '0;
    logic [1:0]     last_id = '0;
    always @(negedge clk) begin
        if (!rst) begin
            rd      = q.size();
            hold_s1 = '0;
            hold_s2 = '0;
            last_d1 = '0;
            last_d2 = '0;
        end else begin
            exp_en = (iss_cyc == cyc);
            if (exp_en) begin
                hold_s1 = nxt_s1;
                hold_s2 = nxt_s2;
            end
            chk("srf_read_enable", DW'(srf_read_enable), DW'(exp_en));
            chk("stream_src1", DW'(stream_src1), DW'(hold_s1));
            chk("stream_src2", DW'(stream_src2), DW'(hold_s2));
            exp_v = (rd < q.size()) && (q[rd].due == cyc);
            if (exp_v) begin
                last_id = q[rd].id;
                last_d1 = pat(req_src1[last_id], 5'h0A);
                last_d2 = pat(req_src2[last_id], 5'h15);
                rd++;
                chk("rsp_id", DW'(rsp_id), DW'(last_id));
            end
            chk("rsp_valid", DW'(rsp_valid), DW'(exp_v));
            chk("rsp_data1", rsp_data1, last_d1);
            chk("rsp_data2", rsp_data2, last_d2);
        end
    end

    task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] lk,
                        input logic [NR-1:0] eg, input string tag);
        exp_t e;
        @(negedge clk);
        req      = r;
        req_lock = lk;
        #1;
        chk(tag, DW'(gnt), DW'(eg));
        if (eg != '0) begin
            e.id = '0;
            for (int i = 0; i < NR; i++) if (eg[i]) e.id = 2'(i);
            e.due = cyc + 3;
            q.push_back(e);
            iss_cyc = cyc + 1;
            nxt_s1  = req_src1[e.id];
            nxt_s2  = req_src2[e.id];
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_gnt"}, DW'(gnt), DW'(0));
        chk({tag, "_en"}, DW'(srf_read_enable), DW'(0));
        chk({tag, "_s1"}, DW'(stream_src1), DW'(0));
        chk({tag, "_s2"}, DW'(stream_src2), DW'(0));
        chk({tag, "_rv"}, DW'(rsp_valid), DW'(0));
        chk({tag, "_rid"}, DW'(rsp_id), DW'(0));
        chk({tag, "_rd1"}, rsp_data1, DW'(0));
        chk({tag, "_rd2"}, rsp_data2, DW'(0));
    endtask

    initial begin
        #2;
        reset_checks("rst0");
        @(negedge clk);
        #2 rst = 1'b1;

`ifdef SRF_ARB_PRIO_EN
        step(4'b0010, 4'b0000, 4'b0010, "p_setup");
        step(4'b0101, 4'b0000, 4'b0001, "p_prio0");
        step(4'b0100, 4'b0000, 4'b0100, "p_then2");
        step(4'b0100, 4'b0100, 4'b0100, "p_lock2");
        step(4'b0101, 4'b0100, 4'b0100, "p_nopreempt");
        step(4'b0101, 4'b0000, 4'b0100, "p_release");
        step(4'b0001, 4'b0000, 4'b0001, "p_after");
        repeat (4) step(4'b0000, 4'b0000, 4'b0000, "p_idle");
`else
        // All requesting: strict rotation
        for (int i = 0; i < 8; i++) begin
            logic [NR-1:0] g;
            g = 4'b0001 << (i % 4);
            step(4'b1111, 4'b0000, g, "rot");
        end
        // Single requester, latency
        step(4'b0100, 4'b0000, 4'b0100, "single2");
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, "idle_a");
        step(4'b0001, 4'b0000, 4'b0001, "ptr_to1");
        // Locked burst with forced release, then ptr wrap
        repeat (4) step(4'b1011, 4'b0010, 4'b0010, "burst1");
        step(4'b1011, 4'b0010, 4'b1000, "after_burst3");
        step(4'b1011, 4'b0010, 4'b0001, "wrap0");
        step(4'b0000, 4'b0000, 4'b0000, "idle_b");
        step(4'b0010, 4'b0000, 4'b0010, "ptr_to2");
        step(4'b0110, 4'b0000, 4'b0100, "alt2a");
        step(4'b0110, 4'b0000, 4'b0010, "alt1a");
        step(4'b0110, 4'b0000, 4'b0100, "alt2b");
        step(4'b0110, 4'b0000, 4'b0010, "alt1b");
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, "idle_c");
        step(4'b0110, 4'b0000, 4'b0100, "ptr_held");
        // Owner drops request while locked
        step(4'b1000, 4'b1000, 4'b1000, "lock3");
        repeat (2) step(4'b0001, 4'b0000, 4'b0000, "owner_gone");
        step(4'b1001, 4'b0000, 4'b1000, "unlock3");
        step(4'b1001, 4'b0000, 4'b0001, "ptr_kept");
        step(4'b0000, 4'b0000, 4'b0000, "idle_d");
        // Reset mid-burst with two tags in flight
        step(4'b0100, 4'b0100, 4'b0100, "mid_a");
        step(4'b0100, 4'b0100, 4'b0100, "mid_b");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        reset_checks("rst_mid");
        iss_cyc = -1;
        repeat (2) @(negedge clk);
        req      = '0;
        req_lock = '0;
        #2 rst = 1'b1;
        repeat (4) step(4'b0000, 4'b0000, 4'b0000, "no_late_rsp");
        step(4'b1111, 4'b0000, 4'b0001, "ptr_reset");
        // Burst count restarted from zero by reset
        repeat (4) step(4'b0101, 4'b0100, 4'b0100, "burst2");
        step(4'b0101, 4'b0100, 4'b0001, "after_burst0");
        repeat (4) step(4'b0000, 4'b0000, 4'b0000, "idle_e");
`endif
        @(negedge clk);
        #1;
        chk("drained", DW'(q.size() - rd), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
